// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared frame constants and types for both ends of the byte-serial CPU bus
package cpu_bus_pkg;

  localparam int FRAME_LEN  = 18;
  localparam int NBYTES     = 8;
  localparam int WORD_W     = 8 * NBYTES;
  localparam int SLOT_W     = 5;
  localparam int FLAG_WRITE = 0;

  localparam logic [SLOT_W-1:0] SLOT_ADDR0 = 5'd1;
  localparam logic [SLOT_W-1:0] SLOT_FLAG  = 5'd9;
  localparam logic [SLOT_W-1:0] SLOT_RD0   = 5'd10;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = 5'd17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_e;

endpackage

// File: rtl/cpu_bus_bridge_target_if.sv
// rtl/cpu_bus_bridge_target_if.sv - pin lanes and parallel memory port of the bridge target
interface cpu_bus_bridge_target_if;
  import cpu_bus_pkg::*;

  logic [7:0]        pin_addr;
  logic [7:0]        pin_data_in;
  logic [7:0]        pin_data_out;
  logic [7:0]        pin_data_oe;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  pin_addr, pin_data_in, mem_rdata, mem_ack,
    output pin_data_out, pin_data_oe, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output pin_addr, pin_data_in, mem_rdata, mem_ack,
    input  pin_data_out, pin_data_oe, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/bus_slot_counter.sv
// rtl/bus_slot_counter.sv - mod-FRAME_LEN slot counter, aligned to the host by the shared reset
module bus_slot_counter
  import cpu_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q + 1'b1;
    if (slot_q == SLOT_W'(FRAME_LEN - 1)) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/cpu_bus_bridge_target.sv
// rtl/cpu_bus_bridge_target.sv - memory-side endpoint: deserialise frame, run one req/ack, serialise read data
module cpu_bus_bridge_target
  import cpu_bus_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  cpu_bus_bridge_target_if.slave   bus,
  input  logic                     err_clr,
  output logic                     late_err,
  output logic                     timeout_err
);

  logic [SLOT_W-1:0] slot;

  bus_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .slot  (slot)
  );

  req_state_e        state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              rd_valid_q, rd_valid_d;
  logic              late_q, late_d;
  logic              timeout_q, timeout_d;

  logic              ack_take;
  logic [2:0]        cap_idx;
  logic [2:0]        rd_idx;
  logic [WORD_W-1:0] rd_src;

  assign ack_take = (state_q == ST_REQ) && bus.mem_ack;
  assign cap_idx  = 3'(slot - SLOT_ADDR0);
  assign rd_idx   = 3'(slot - SLOT_RD0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    rd_valid_d = rd_valid_q;
    late_d     = err_clr ? 1'b0 : late_q;
    timeout_d  = err_clr ? 1'b0 : timeout_q;

    if (slot >= SLOT_ADDR0 && slot < SLOT_FLAG) begin
      addr_d[{cap_idx, 3'b000} +: 8]  = bus.pin_addr;
      wdata_d[{cap_idx, 3'b000} +: 8] = bus.pin_data_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (slot == SLOT_FLAG) begin
          we_d       = bus.pin_addr[FLAG_WRITE];
          rd_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the last slot still completes the transaction rather than timing out.
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            rdata_d    = bus.mem_rdata;
            rd_valid_d = 1'b1;
            if (slot > SLOT_RD0) begin
              late_d = 1'b1;
            end
          end
        end else if (slot == SLOT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      late_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      rd_valid_q <= rd_valid_d;
      late_q     <= late_d;
      timeout_q  <= timeout_d;
    end
  end

  // Zero-wait bypass lets byte 0 go out in the same slot the memory acks.
  always_comb begin
    rd_src           = '0;
    bus.pin_data_out = 8'h00;
    bus.pin_data_oe  = 8'h00;
    if (ack_take) begin
      rd_src = bus.mem_rdata;
    end else if (rd_valid_q) begin
      rd_src = rdata_q;
    end
    if (slot >= SLOT_RD0 && !we_q) begin
      bus.pin_data_oe  = 8'hFF;
      bus.pin_data_out = rd_src[{rd_idx, 3'b000} +: 8];
    end
  end

  assign bus.mem_req   = (state_q == ST_REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign late_err      = late_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_cpu_bus_bridge_target.sv
// tb/tb_cpu_bus_bridge_target.sv - frame-driving scoreboard bench for cpu_bus_bridge_target
module tb_cpu_bus_bridge_target;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic late_err;
  logic timeout_err;

  cpu_bus_bridge_target_if bus ();

  cpu_bus_bridge_target dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_clr     (err_clr),
    .late_err    (late_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  req_t       req_sb[$];
  logic [7:0] byte_sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         exp_late = 1'b0;
  bit         exp_to = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, bus.mem_req, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_oe"}, bus.pin_data_oe, 0);
    check({tag, "_out"}, bus.pin_data_out, 0);
    check({tag, "_late"}, late_err, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Starts in slot 0 shortly after a negedge; returns in slot 0 of the next frame.
  task automatic run_frame(input logic [63:0] addr, input logic [63:0] wdata, input bit we,
                           input int ack_slot, input logic [63:0] rdata, input bit clr,
                           input bit stray0, input int abort_slot);
    bit   acked;
    req_t r;
    logic [7:0] exp_b;
    acked = (ack_slot >= 10) && (ack_slot <= 17);
    r.we = we;
    r.addr = addr;
    r.wdata = wdata;
    req_sb.push_back(r);
    if (!we) begin
      for (int b = 0; b < 8; b++) begin
        byte_sb.push_back((acked && (10 + b) >= ack_slot) ? rdata[8*b +: 8] : 8'h00);
      end
    end
    for (int s = 0; s < FRAME_LEN; s++) begin
      bus.pin_addr    = (s >= 1 && s <= 8) ? addr[8*(s-1) +: 8] :
                        (s == 9) ? {7'($urandom), we} : 8'($urandom);
      bus.pin_data_in = (s >= 1 && s <= 8) ? wdata[8*(s-1) +: 8] : 8'($urandom);
      bus.mem_ack     = (s == ack_slot) || (stray0 && s == 0);
      bus.mem_rdata   = (s == ack_slot) ? rdata : {$urandom, $urandom};
      err_clr         = clr && (s == 1);
      if (clr && s == 1) begin
        exp_late = 1'b0;
        exp_to = 1'b0;
      end
      #1;
      check("mem_req", bus.mem_req, (s >= 10) && (!acked || s <= ack_slot));
      if (s == 10) begin
        r = req_sb.pop_front();
        check("mem_we", bus.mem_we, r.we);
        check("mem_addr", bus.mem_addr, r.addr);
        check("mem_wdata", bus.mem_wdata, r.wdata);
      end
      if (!we && s >= 10) begin
        check("rd_oe", bus.pin_data_oe, 8'hFF);
        if (byte_sb.size() == 0) begin
          check("rd_sb_empty", 1, 0);
        end else begin
          exp_b = byte_sb.pop_front();
          check("rd_byte", bus.pin_data_out, exp_b);
        end
      end else begin
        check("idle_oe", bus.pin_data_oe, 8'h00);
        check("idle_out", bus.pin_data_out, 8'h00);
      end
      if (s == abort_slot) begin
        rst_n = 1'b0;
        bus.mem_ack = 1'b0;
        err_clr = 1'b0;
        #1;
        check_all_zero("abort");
        byte_sb.delete();
        req_sb.delete();
        exp_late = 1'b0;
        exp_to = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    err_clr = 1'b0;
    if (acked && !we && ack_slot > 10) exp_late = 1'b1;
    if (!acked) exp_to = 1'b1;
    #1;
    check("req_after_frame", bus.mem_req, 0);
    check("late_err", late_err, exp_late);
    check("timeout_err", timeout_err, exp_to);
  endtask

  initial begin
    int   ack;
    bit   we;
    logic [63:0] a, w, d;
    bus.pin_addr = '0;
    bus.pin_data_in = '0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    run_frame(64'h0807060504030201, 64'h8877665544332211, 1, 12, 64'hDEADBEEFCAFEF00D, 0, 0, -1);
    run_frame(64'h0000_1000_2000_3000, 64'h0, 0, 10, 64'hF0E0D0C0B0A09080, 0, 0, -1);
    run_frame(64'h1111_2222_3333_4444, 64'h0, 0, 13, 64'h0123456789ABCDEF, 0, 0, -1);
    run_frame(64'hAAAA_5555_AAAA_5555, 64'h0, 0, 10, 64'h5A5A5A5AA5A5A5A5, 1, 0, -1);
    run_frame(64'h4444_0000_4444_0000, 64'h0, 0, -1, 64'h0, 0, 0, -1);
    run_frame(64'h7777_6666_5555_4444, 64'h99, 1, 11, 64'h0, 0, 1, -1);
    run_frame(64'h5, 64'h6, 0, 11, 64'h0, 1, 0, -1);

    run_frame(64'hBAD0_BAD0_BAD0_BAD0, 64'h0, 0, -1, 64'h0, 0, 0, 11);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(64'hFEDC_BA98_7654_3210, 64'h0F1E2D3C4B5A6978, 1, 10, 64'h0, 0, 0, -1);

    run_frame(64'h10, 64'h20, 1, 14, 64'h0, 0, 0, -1);
    run_frame(64'h30, 64'h0, 0, 12, 64'h1357_9BDF_2468_ACE0, 0, 0, -1);
    run_frame(64'h40, 64'h0, 0, -1, 64'h0, 0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      we = 1'($urandom);
      ack = $urandom_range(9, 17);
      if (ack == 9) ack = -1;
      a = {$urandom, $urandom};
      w = {$urandom, $urandom};
      d = {$urandom, $urandom};
      run_frame(a, w, we, ack, d, 1'($urandom), 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
